// File: rtl/cardinal_nic_pkg.sv
// Shared NIC/router definitions: cpu-side register map, packet field layout, status word helper.
// Packets are big-endian: bit 0 is the most significant bit of the 64-bit word.
package cardinal_nic_pkg;

   localparam int NIC_DATA_W = 64;
   localparam int NIC_ADDR_W = 2;

   typedef logic [0:NIC_DATA_W-1] nic_pkt_t;

   typedef enum logic [NIC_ADDR_W-1:0] {
      NIC_ADDR_INBUF   = 2'b00,
      NIC_ADDR_INSTAT  = 2'b01,
      NIC_ADDR_OUTBUF  = 2'b10,
      NIC_ADDR_OUTSTAT = 2'b11
   } nic_addr_e;

   localparam int PKT_VC_BIT      = 0;
   localparam int PKT_DIR_BIT     = 1;
   localparam int PKT_HOP_OFS     = 8;
   localparam int PKT_HOP_W       = 8;
   localparam int PKT_SRC_OFS     = 16;
   localparam int PKT_SRC_W       = 16;
   localparam int PKT_PAYLOAD_OFS = 32;
   localparam int PKT_PAYLOAD_W   = 32;

   // Full flag lands in bit 63, the least significant bit in big-endian numbering.
   function automatic nic_pkt_t nic_status(input logic full);
      return {{(NIC_DATA_W-1){1'b0}}, full};
   endfunction

   function automatic nic_pkt_t pkt_make(input logic vc, input logic dir,
                                         input logic [PKT_HOP_W-1:0] hop,
                                         input logic [PKT_SRC_W-1:0] src,
                                         input logic [PKT_PAYLOAD_W-1:0] payload);
      nic_pkt_t p;
      p = '0;
      p[PKT_VC_BIT] = vc;
      p[PKT_DIR_BIT] = dir;
      p[PKT_HOP_OFS +: PKT_HOP_W] = hop;
      p[PKT_SRC_OFS +: PKT_SRC_W] = src;
      p[PKT_PAYLOAD_OFS +: PKT_PAYLOAD_W] = payload;
      return p;
   endfunction

endpackage

// File: rtl/cardinal_nic_if.sv
// CPU register bus plus router link of one NIC. A transfer on either router direction happens on a
// clock edge where the sender's s-line and the receiver's r-line are both high in that cycle.
interface cardinal_nic_if;
   import cardinal_nic_pkg::*;

   logic [NIC_ADDR_W-1:0] nicAddr;
   nic_pkt_t              nicDataOut;
   logic                  nicEn;
   logic                  nicWrEn;
   nic_pkt_t              nicDataIn;
   logic                  net_si;
   logic                  net_ri;
   nic_pkt_t              net_di;
   logic                  net_so;
   logic                  net_ro;
   nic_pkt_t              net_do;
   logic                  net_polarity;

   modport master (
      output nicAddr, nicDataOut, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
      input  nicDataIn, net_ri, net_so, net_do
   );

   modport slave (
      input  nicAddr, nicDataOut, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
      output nicDataIn, net_ri, net_so, net_do
   );

endinterface

// File: rtl/nic_chan_buf.sv
// One-entry packet buffer with a full flag. Callers never assert wr and clear together:
// wr is only legal while empty, clear only while full.
module nic_chan_buf #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr,
   input  logic [0:W-1] din,
   input  logic         clear,
   output logic [0:W-1] dout,
   output logic         full
);

   always_ff @(posedge clk) begin
      if (reset) begin
         dout <= '0;
         full <= 1'b0;
      end else if (clear) begin
         full <= 1'b0;
      end else if (wr) begin
         dout <= din;
         full <= 1'b1;
      end
   end

endmodule

// File: rtl/cardinal_nic.sv
// NIC between a cardinal cpu core and its ring router port: one packet buffer per direction,
// memory-mapped to the cpu, with output injection gated by ring polarity against the packet VC bit.
module cardinal_nic
   import cardinal_nic_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   cardinal_nic_if.slave bus
);

   logic     cpu_rd;
   logic     cpu_wr;
   logic     in_full;
   logic     out_full;
   nic_pkt_t in_buf;
   nic_pkt_t out_buf;
   logic     in_take;
   logic     in_clear;
   logic     out_load;
   logic     out_send;

   assign cpu_rd = bus.nicEn && !bus.nicWrEn;
   assign cpu_wr = bus.nicEn && bus.nicWrEn;

   // Reading the in-buffer while full consumes it; a write into a full out-buffer is dropped.
   assign in_clear = cpu_rd && (bus.nicAddr == NIC_ADDR_INBUF) && in_full;
   assign in_take  = bus.net_si && !in_full;
   assign out_load = cpu_wr && (bus.nicAddr == NIC_ADDR_OUTBUF) && !out_full;
   assign out_send = !reset && out_full && bus.net_ro && (out_buf[PKT_VC_BIT] == bus.net_polarity);

   assign bus.net_ri = !reset && !in_full;
   assign bus.net_so = out_send;
   assign bus.net_do = out_buf;

   nic_chan_buf #(.W(NIC_DATA_W)) u_in_buf (
      .clk   (clk),
      .reset (reset),
      .wr    (in_take),
      .din   (bus.net_di),
      .clear (in_clear),
      .dout  (in_buf),
      .full  (in_full)
   );

   nic_chan_buf #(.W(NIC_DATA_W)) u_out_buf (
      .clk   (clk),
      .reset (reset),
      .wr    (out_load),
      .din   (bus.nicDataOut),
      .clear (out_send),
      .dout  (out_buf),
      .full  (out_full)
   );

   always_comb begin
      bus.nicDataIn = '0;
      if (!reset && cpu_rd) begin
         unique case (nic_addr_e'(bus.nicAddr))
            NIC_ADDR_INBUF:   bus.nicDataIn = in_buf;
            NIC_ADDR_INSTAT:  bus.nicDataIn = nic_status(in_full);
            NIC_ADDR_OUTBUF:  bus.nicDataIn = out_buf;
            NIC_ADDR_OUTSTAT: bus.nicDataIn = nic_status(out_full);
         endcase
      end
   end

endmodule

// File: tb/tb_cardinal_nic.sv
// Directed scenarios plus a randomized run of cardinal_nic, checked against a packet-queue model.
module tb_cardinal_nic;
   import cardinal_nic_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cardinal_nic_if bus ();

   cardinal_nic dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Scoreboard: packets held in each direction (at most one) and the last value loaded into each buffer.
   logic [63:0] exp_q[$];
   logic [63:0] out_q[$];
   logic [63:0] in_last;
   logic [63:0] out_last;

   function automatic logic m_ri();
      return !reset && (exp_q.size() == 0);
   endfunction

   function automatic logic m_so();
      if (reset || out_q.size() == 0 || !bus.net_ro) return 1'b0;
      return out_q[0][63] == bus.net_polarity;
   endfunction

   function automatic logic [63:0] m_read();
      if (reset || !bus.nicEn || bus.nicWrEn) return 64'h0;
      case (bus.nicAddr)
         2'b00:   return (exp_q.size() != 0) ? exp_q[0] : in_last;
         2'b01:   return {63'h0, exp_q.size() != 0};
         2'b10:   return (out_q.size() != 0) ? out_q[0] : out_last;
         default: return {63'h0, out_q.size() != 0};
      endcase
   endfunction

   // Advance the model by one clock edge using the inputs presented this cycle, then step the DUT.
   task automatic tick();
      logic in_full, out_full, send;
      if (reset) begin
         exp_q.delete();
         out_q.delete();
         in_last = '0;
         out_last = '0;
      end else begin
         in_full  = exp_q.size() != 0;
         out_full = out_q.size() != 0;
         send     = m_so();
         if (bus.nicEn && !bus.nicWrEn && bus.nicAddr == 2'b00 && in_full)
            void'(exp_q.pop_front());
         else if (bus.net_si && !in_full) begin
            exp_q.push_back(bus.net_di);
            in_last = bus.net_di;
         end
         if (send)
            void'(out_q.pop_front());
         else if (bus.nicEn && bus.nicWrEn && bus.nicAddr == 2'b10 && !out_full) begin
            out_q.push_back(bus.nicDataOut);
            out_last = bus.nicDataOut;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      bus.nicEn = 1'b0;
      bus.nicWrEn = 1'b0;
      bus.nicAddr = 2'b00;
      bus.nicDataOut = '0;
      bus.net_si = 1'b0;
      bus.net_di = '0;
   endtask

   task automatic cpu(input logic we, input logic [1:0] addr, input logic [63:0] d);
      bus.nicEn = 1'b1;
      bus.nicWrEn = we;
      bus.nicAddr = addr;
      bus.nicDataOut = d;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.net_ro = 1'b1;
      cpu(1'b0, 2'b11, 64'h0);
      #1;
      n_checks++; if (bus.net_ri !== 1'b0) begin n_fail++; $display("FAIL reset_hold_ri got=%0b exp=0", bus.net_ri); end
      n_checks++; if (bus.nicDataIn !== 64'h0) begin n_fail++; $display("FAIL reset_hold_data got=%h exp=0", bus.nicDataIn); end
      tick();
      tick();
      reset = 1'b0;
      cpu(1'b0, 2'b01, 64'h0);
      #1;
      n_checks++; if (bus.net_ri !== 1'b1) begin n_fail++; $display("FAIL reset_ri got=%0b exp=1", bus.net_ri); end
      n_checks++; if (bus.net_so !== 1'b0) begin n_fail++; $display("FAIL reset_so got=%0b exp=0", bus.net_so); end
      n_checks++; if (bus.nicDataIn !== 64'h0) begin n_fail++; $display("FAIL reset_instat got=%h exp=0", bus.nicDataIn); end
      cpu(1'b0, 2'b11, 64'h0);
      #1;
      n_checks++; if (bus.nicDataIn !== 64'h0) begin n_fail++; $display("FAIL reset_outstat got=%h exp=0", bus.nicDataIn); end
      idle();
      tick();
   endtask

   task automatic test_ingress();
      bus.net_si = 1'b1;
      bus.net_di = 64'hDEAD_BEEF_0123_4567;
      tick();
      bus.net_si = 1'b0;
      cpu(1'b0, 2'b01, 64'h0);
      #1;
      n_checks++; if (bus.net_ri !== 1'b0) begin n_fail++; $display("FAIL ingress_ri_full got=%0b exp=0", bus.net_ri); end
      n_checks++; if (bus.nicDataIn !== 64'h1) begin n_fail++; $display("FAIL ingress_instat got=%h exp=1", bus.nicDataIn); end
      tick();
      cpu(1'b0, 2'b00, 64'h0);
      #1;
      n_checks++; if (bus.nicDataIn !== 64'hDEAD_BEEF_0123_4567) begin n_fail++; $display("FAIL ingress_data got=%h exp=deadbeef01234567", bus.nicDataIn); end
      tick();
      cpu(1'b0, 2'b01, 64'h0);
      #1;
      n_checks++; if (bus.nicDataIn !== 64'h0) begin n_fail++; $display("FAIL ingress_consumed got=%h exp=0", bus.nicDataIn); end
      n_checks++; if (bus.net_ri !== 1'b1) begin n_fail++; $display("FAIL ingress_ri_empty got=%0b exp=1", bus.net_ri); end
      idle();
      tick();
   endtask

   task automatic test_egress_polarity();
      bus.net_ro = 1'b1;
      bus.net_polarity = 1'b0;
      cpu(1'b1, 2'b10, 64'h8000_0000_0000_00AA);
      #1;
      n_checks++; if (bus.net_so !== 1'b0) begin n_fail++; $display("FAIL egress_so_empty got=%0b exp=0", bus.net_so); end
      tick();
      idle();
      #1;
      n_checks++; if (bus.net_so !== 1'b0) begin n_fail++; $display("FAIL egress_so_wrong_pol got=%0b exp=0", bus.net_so); end
      bus.net_polarity = 1'b1;
      #1;
      n_checks++; if (bus.net_so !== 1'b1) begin n_fail++; $display("FAIL egress_so got=%0b exp=1", bus.net_so); end
      n_checks++; if (bus.net_do !== 64'h8000_0000_0000_00AA) begin n_fail++; $display("FAIL egress_do got=%h exp=80000000000000aa", bus.net_do); end
      tick();
      bus.net_polarity = 1'b0;
      cpu(1'b0, 2'b11, 64'h0);
      #1;
      n_checks++; if (bus.nicDataIn !== 64'h0) begin n_fail++; $display("FAIL egress_outstat got=%h exp=0", bus.nicDataIn); end
      idle();
      tick();
   endtask

   task automatic test_backpressure();
      bus.net_ro = 1'b0;
      bus.net_polarity = 1'b0;
      cpu(1'b1, 2'b10, 64'h0000_0000_0000_0BEE);
      tick();
      cpu(1'b1, 2'b10, 64'h1234);
      tick();
      cpu(1'b0, 2'b10, 64'h0);
      #1;
      n_checks++; if (bus.nicDataIn !== 64'h0BEE) begin n_fail++; $display("FAIL drop_outbuf got=%h exp=bee", bus.nicDataIn); end
      cpu(1'b0, 2'b11, 64'h0);
      #1;
      n_checks++; if (bus.nicDataIn !== 64'h1) begin n_fail++; $display("FAIL drop_outstat got=%h exp=1", bus.nicDataIn); end
      // Send and a new write on the same edge: the write sees the buffer still full and is lost.
      bus.net_ro = 1'b1;
      cpu(1'b1, 2'b10, 64'h999);
      #1;
      n_checks++; if (bus.net_so !== 1'b1) begin n_fail++; $display("FAIL drop_so got=%0b exp=1", bus.net_so); end
      tick();
      cpu(1'b0, 2'b11, 64'h0);
      #1;
      n_checks++; if (bus.nicDataIn !== 64'h0) begin n_fail++; $display("FAIL send_write_outstat got=%h exp=0", bus.nicDataIn); end
      cpu(1'b0, 2'b10, 64'h0);
      #1;
      n_checks++; if (bus.nicDataIn !== 64'h0BEE) begin n_fail++; $display("FAIL send_write_outbuf got=%h exp=bee", bus.nicDataIn); end
      idle();
      tick();
   endtask

   task automatic test_collision();
      bus.net_si = 1'b1;
      bus.net_di = 64'hA;
      tick();
      bus.net_di = 64'h55;
      cpu(1'b0, 2'b00, 64'h0);
      #1;
      n_checks++; if (bus.net_ri !== 1'b0) begin n_fail++; $display("FAIL collide_ri got=%0b exp=0", bus.net_ri); end
      n_checks++; if (bus.nicDataIn !== 64'hA) begin n_fail++; $display("FAIL collide_read got=%h exp=a", bus.nicDataIn); end
      tick();
      idle();
      bus.net_si = 1'b1;
      bus.net_di = 64'h55;
      #1;
      n_checks++; if (bus.net_ri !== 1'b1) begin n_fail++; $display("FAIL collide_resend_ri got=%0b exp=1", bus.net_ri); end
      tick();
      idle();
      cpu(1'b0, 2'b01, 64'h0);
      #1;
      n_checks++; if (bus.nicDataIn !== 64'h1) begin n_fail++; $display("FAIL collide_instat got=%h exp=1", bus.nicDataIn); end
      cpu(1'b0, 2'b00, 64'h0);
      #1;
      n_checks++; if (bus.nicDataIn !== 64'h55) begin n_fail++; $display("FAIL collide_data got=%h exp=55", bus.nicDataIn); end
      tick();
      idle();
      tick();
   endtask

   task automatic test_reset_mid_op();
      bus.net_ro = 1'b1;
      bus.net_polarity = 1'b0;
      bus.net_si = 1'b1;
      bus.net_di = 64'h77;
      cpu(1'b1, 2'b10, 64'h8000_0000_0000_0001);
      tick();
      idle();
      reset = 1'b1;
      bus.net_polarity = 1'b1;
      cpu(1'b0, 2'b01, 64'h0);
      #1;
      n_checks++; if (bus.net_so !== 1'b0) begin n_fail++; $display("FAIL midreset_so got=%0b exp=0", bus.net_so); end
      n_checks++; if (bus.net_ri !== 1'b0) begin n_fail++; $display("FAIL midreset_ri got=%0b exp=0", bus.net_ri); end
      n_checks++; if (bus.nicDataIn !== 64'h0) begin n_fail++; $display("FAIL midreset_data got=%h exp=0", bus.nicDataIn); end
      tick();
      reset = 1'b0;
      #1;
      n_checks++; if (bus.nicDataIn !== 64'h0) begin n_fail++; $display("FAIL midreset_instat got=%h exp=0", bus.nicDataIn); end
      cpu(1'b0, 2'b11, 64'h0);
      #1;
      n_checks++; if (bus.nicDataIn !== 64'h0) begin n_fail++; $display("FAIL midreset_outstat got=%h exp=0", bus.nicDataIn); end
      n_checks++; if (bus.net_so !== 1'b0) begin n_fail++; $display("FAIL midreset_so_after got=%0b exp=0", bus.net_so); end
      idle();
      tick();
   endtask

   task automatic test_random();
      logic [63:0] exp_data;
      logic        exp_so;
      for (int i = 0; i < 600; i++) begin
         reset = ($urandom_range(0, 99) == 0);
         bus.net_si = $urandom_range(0, 1);
         bus.net_di = pkt_make($urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom),
                               16'($urandom), $urandom);
         bus.net_ro = $urandom_range(0, 3) != 0;
         bus.net_polarity = $urandom_range(0, 1);
         bus.nicEn = $urandom_range(0, 2) != 0;
         bus.nicWrEn = $urandom_range(0, 1);
         bus.nicAddr = 2'($urandom_range(0, 3));
         bus.nicDataOut = {$urandom, $urandom};
         #1;
         exp_so = m_so();
         exp_data = m_read();
         n_checks++; if (bus.net_ri !== m_ri()) begin n_fail++; $display("FAIL rand_ri cyc=%0d got=%0b exp=%0b", i, bus.net_ri, m_ri()); end
         n_checks++; if (bus.net_so !== exp_so) begin n_fail++; $display("FAIL rand_so cyc=%0d got=%0b exp=%0b", i, bus.net_so, exp_so); end
         if (exp_so) begin
            n_checks++; if (bus.net_do !== out_q[0]) begin n_fail++; $display("FAIL rand_do cyc=%0d got=%h exp=%h", i, bus.net_do, out_q[0]); end
         end
         n_checks++; if (bus.nicDataIn !== exp_data) begin n_fail++; $display("FAIL rand_read cyc=%0d addr=%0d got=%h exp=%h", i, bus.nicAddr, bus.nicDataIn, exp_data); end
         tick();
      end
      reset = 1'b0;
      idle();
   endtask

   initial begin
      reset = 1'b1;
      in_last = '0;
      out_last = '0;
      bus.net_ro = 1'b0;
      bus.net_polarity = 1'b0;
      idle();
      @(negedge clk);
      test_reset();
      test_ingress();
      test_egress_polarity();
      test_backpressure();
      test_collision();
      test_reset_mid_op();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
